// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter-side signal bundle for uart_tx_queue.
// slave = the queue itself, master = whoever drives the writes and models the UART.
interface uart_tx_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_en;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    ovf_clr;
  logic                    overflow;

  modport slave (
    input  wr_en, wr_data, tx_busy, tx_done, ovf_clr,
    output tx_data, tx_en, full, empty, count, overflow
  );

  modport master (
    output wr_en, wr_data, tx_busy, tx_done, ovf_clr,
    input  tx_data, tx_en, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: circular buffer plus a launch FSM that
// pulses tx_en once per byte. Sticky overflow flag only with UART_TX_QUEUE_OVERFLOW_EN.
module uart_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic          clk,
  input logic          rst,
  uart_tx_queue_if.slave q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt;
  logic                  full_r;
  logic                  empty_r;
  logic                  tx_en_r;
  logic [DATA_WIDTH-1:0] tx_data_r;
  logic                  push;
  logic                  pop;

  // A write while full is lost even if a pop frees a slot on the same edge.
  assign push = q.wr_en && !full_r;
  assign pop  = (state == IDLE) && !empty_r && !q.tx_busy;

  always_comb begin
    count_nxt = count_r;
    if (push && !pop)
      count_nxt = count_r + 1'b1;
    else if (pop && !push)
      count_nxt = count_r - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= q.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      count_r <= count_nxt;
      full_r  <= (count_nxt == DEPTH_C);
      empty_r <= (count_nxt == '0);
    end
  end

  // tx_en is registered, so it is high in the cycle after LAUNCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      tx_en_r   <= 1'b0;
      tx_data_r <= '0;
    end else begin
      tx_en_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_r <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en_r <= 1'b1;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (q.tx_busy)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (q.tx_done || !q.tx_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic ovf_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_r <= 1'b0;
    else if (q.wr_en && full_r)
      ovf_r <= 1'b1;
    else if (q.ovf_clr)
      ovf_r <= 1'b0;
  end
  assign q.overflow = ovf_r;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = q.ovf_clr;
  assign q.overflow     = 1'b0;
`endif

  assign q.tx_data = tx_data_r;
  assign q.tx_en   = tx_en_r;
  assign q.full    = full_r;
  assign q.empty   = empty_r;
  assign q.count   = count_r;
endmodule
